// File: rtl/envelope_generator_pkg.sv
// ---------------------------------------------------------------------------
// envelope_generator_pkg
//
// Definitions shared by the envelope generator and the oscillator blocks:
// state encodings, level/gain/step widths and a helper that turns an 8-bit
// rate control into the 9-bit per-tick step (rate + 1).
// ---------------------------------------------------------------------------
package envelope_generator_pkg;

    localparam int LEVEL_W = 16;   // internal envelope level width
    localparam int GAIN_W  = 8;    // gain output width (level MSBs)
    localparam int RATE_W  = 8;    // rate / sustain control width
    localparam int STEP_W  = 9;    // rate + 1 needs one extra bit

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LEVEL_MIN = '0;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    // A rate of 8'hFF gives a step of 256, so the result is 9 bits wide.
    function automatic logic [STEP_W-1:0] rate_to_step(input logic [RATE_W-1:0] rate);
        return {1'b0, rate} + {{(STEP_W-1){1'b0}}, 1'b1};
    endfunction

endpackage : envelope_generator_pkg

// File: rtl/envelope_step.sv
// ---------------------------------------------------------------------------
// envelope_step
//
// Purely combinational saturating step of the envelope level.
//   add mode : sum = level + step (17 bits). If the sum exceeds the bound the
//              result clamps to the bound and o_reached is set.
//   sub mode : if level <= bound + step (17-bit compare) the result lands
//              exactly on the bound and o_reached is set, otherwise the
//              result is level - step.
//
// Ports
//   i_add      : 1 = add toward an upper bound, 0 = subtract toward a lower one
//   i_level    : current 16-bit level
//   i_step     : 9-bit step (rate + 1)
//   i_bound    : 16-bit bound (upper in add mode, lower in sub mode)
//   o_level    : next level candidate
//   o_reached  : bound reached (phase complete)
// ---------------------------------------------------------------------------
module envelope_step
    import envelope_generator_pkg::*;
(
    input  logic                i_add,
    input  logic [LEVEL_W-1:0]  i_level,
    input  logic [STEP_W-1:0]   i_step,
    input  logic [LEVEL_W-1:0]  i_bound,
    output logic [LEVEL_W-1:0]  o_level,
    output logic                o_reached
);

    logic [LEVEL_W:0] w_step_ext;
    logic [LEVEL_W:0] w_level_ext;
    logic [LEVEL_W:0] w_bound_ext;
    logic [LEVEL_W:0] w_sum;
    logic [LEVEL_W:0] w_floor;
    logic [LEVEL_W:0] w_diff;

    assign w_step_ext  = {{(LEVEL_W+1-STEP_W){1'b0}}, i_step};
    assign w_level_ext = {1'b0, i_level};
    assign w_bound_ext = {1'b0, i_bound};

    // All arithmetic is carried in 17 bits so nothing can wrap.
    assign w_sum   = w_level_ext + w_step_ext;
    assign w_floor = w_bound_ext + w_step_ext;
    assign w_diff  = w_level_ext - w_step_ext;

    always_comb begin
        o_level   = i_level;
        o_reached = 1'b0;
        if (i_add) begin
            if (w_sum > w_bound_ext) begin
                o_level   = i_bound;
                o_reached = 1'b1;
            end else begin
                o_level   = w_sum[LEVEL_W-1:0];
            end
        end else begin
            // level <= bound + step means one more step would reach or pass
            // the bound, so land on it exactly.
            if (w_level_ext <= w_floor) begin
                o_level   = i_bound;
                o_reached = 1'b1;
            end else begin
                o_level   = w_diff[LEVEL_W-1:0];
            end
        end
    end

endmodule : envelope_step

// File: rtl/envelope_generator.sv
// ---------------------------------------------------------------------------
// envelope_generator
//
// ADSR envelope generator. A 16-bit level register is stepped once per
// sample-rate tick according to the current phase; gain is the top byte of
// that register with no extra stage, so it can feed the wave gain stage
// directly.
//
// Gate handling is evaluated every clk, independent of tick:
//   - a rising edge of gate (gate & ~gate_d) in any state enters ATTACK with
//     the level kept as-is (legato retrigger);
//   - gate low in ATTACK/DECAY/SUSTAIN enters RELEASE with the level kept.
// A cycle that takes a gate-driven transition never moves the level, even if
// tick is high on that cycle.
//
// Ports
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset, overrides gate and tick
//   tick           : sample-rate strobe, one clk wide
//   gate           : note-on level
//   attack_rate    : attack step = attack_rate + 1 per tick
//   decay_rate     : decay step = decay_rate + 1 per tick
//   sustain_level  : sustain gain (8'hFF full, 8'h00 silent)
//   release_rate   : release step = release_rate + 1 per tick
//   gain           : level[15:8]
//   active         : state != IDLE
//   env_state      : current state encoding (debug)
// ---------------------------------------------------------------------------
module envelope_generator
    import envelope_generator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               gate,
    input  logic [RATE_W-1:0]  attack_rate,
    input  logic [RATE_W-1:0]  decay_rate,
    input  logic [RATE_W-1:0]  sustain_level,
    input  logic [RATE_W-1:0]  release_rate,
    output logic [GAIN_W-1:0]  gain,
    output logic               active,
    output logic [2:0]         env_state
);

    env_state_e          r_state;
    logic [LEVEL_W-1:0]  r_level;
    logic                r_gate_d;

    logic                w_gate_rise;
    logic                w_gate_release;
    logic                w_step_add;
    logic [STEP_W-1:0]   w_step;
    logic [LEVEL_W-1:0]  w_bound;
    logic [LEVEL_W-1:0]  w_sustain_target;
    logic [LEVEL_W-1:0]  w_next_level;
    logic                w_reached;

    assign w_gate_rise      = gate & ~r_gate_d;
    assign w_gate_release   = ~gate && ((r_state == ENV_ATTACK) ||
                                        (r_state == ENV_DECAY)  ||
                                        (r_state == ENV_SUSTAIN));
    assign w_sustain_target = {sustain_level, 8'h00};

    // Select step, bound and direction for the shared step unit. Rates and
    // sustain are read live, so a change takes effect on the next tick.
    always_comb begin
        w_step_add = 1'b0;
        w_step     = rate_to_step(release_rate);
        w_bound    = LEVEL_MIN;
        case (r_state)
            ENV_ATTACK: begin
                w_step_add = 1'b1;
                w_step     = rate_to_step(attack_rate);
                w_bound    = LEVEL_MAX;
            end
            ENV_DECAY: begin
                w_step     = rate_to_step(decay_rate);
                w_bound    = w_sustain_target;
            end
            default: begin
                w_step_add = 1'b0;
                w_step     = rate_to_step(release_rate);
                w_bound    = LEVEL_MIN;
            end
        endcase
    end

    envelope_step u_step (
        .i_add     (w_step_add),
        .i_level   (r_level),
        .i_step    (w_step),
        .i_bound   (w_bound),
        .o_level   (w_next_level),
        .o_reached (w_reached)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ENV_IDLE;
            r_level  <= LEVEL_MIN;
            r_gate_d <= 1'b0;
        end else begin
            r_gate_d <= gate;
            if (w_gate_rise) begin
                r_state <= ENV_ATTACK;
            end else if (w_gate_release) begin
                r_state <= ENV_RELEASE;
            end else begin
                case (r_state)
                    ENV_IDLE: begin
                        r_level <= LEVEL_MIN;
                    end
                    ENV_ATTACK: begin
                        if (tick) begin
                            r_level <= w_next_level;
                            if (w_reached) begin
                                r_state <= ENV_DECAY;
                            end
                        end
                    end
                    ENV_DECAY: begin
                        if (tick) begin
                            r_level <= w_next_level;
                            if (w_reached) begin
                                r_state <= ENV_SUSTAIN;
                            end
                        end
                    end
                    ENV_SUSTAIN: begin
                        // Tracks live sustain changes on every tick.
                        if (tick) begin
                            r_level <= w_sustain_target;
                        end
                    end
                    ENV_RELEASE: begin
                        if (tick) begin
                            r_level <= w_next_level;
                            if (w_reached) begin
                                r_state <= ENV_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ENV_IDLE;
                    end
                endcase
            end
        end
    end

    assign gain      = r_level[LEVEL_W-1 -: GAIN_W];
    assign active    = (r_state != ENV_IDLE);
    assign env_state = r_state;

endmodule : envelope_generator

// File: tb/tb_envelope_generator.sv
// ---------------------------------------------------------------------------
// tb_envelope_generator
//
// Directed bench for envelope_generator. A table of {inputs, cycles, expected
// outputs} records walks a full attack/decay/sustain/release cycle; short
// hand-written sequences cover retrigger, gate edge coincident with tick,
// reset mid-attack, slow attack and zero sustain.
// ---------------------------------------------------------------------------
module tb_envelope_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       gate;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [7:0] gain;
    logic       active;
    logic [2:0] env_state;

    int n_checks = 0;
    int n_errors = 0;

    envelope_generator dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .gain          (gain),
        .active        (active),
        .env_state     (env_state)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        gate;
        logic        tick;
        logic [7:0]  sus;
        logic [15:0] cycles;
        logic [7:0]  exp_gain;
        logic [2:0]  exp_state;
        logic        exp_active;
    } vec_t;

    vec_t vecs [13];

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [7:0] eg,
                             input logic [2:0] es, input logic ea);
        n_checks++;
        if (gain !== eg) begin
            n_errors++;
            $display("FAIL %s gain got %h expected %h", name, gain, eg);
        end
        n_checks++;
        if (env_state !== es) begin
            n_errors++;
            $display("FAIL %s env_state got %0d expected %0d", name, env_state, es);
        end
        n_checks++;
        if (active !== ea) begin
            n_errors++;
            $display("FAIL %s active got %b expected %b", name, active, ea);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        gate = 1'b0;
        tick = 1'b1;
        run(2);
        rst  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        tick          = 1'b1;
        gate          = 1'b0;
        attack_rate   = 8'hFF;
        decay_rate    = 8'hFF;
        sustain_level = 8'h80;
        release_rate  = 8'hFF;

        // rst gate tick sus cycles gain state active
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h80, 16'd2,   8'h00, 3'd0, 1'b0}; // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h80, 16'd3,   8'h00, 3'd0, 1'b0}; // idle
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h80, 16'd1,   8'h00, 3'd1, 1'b1}; // gate edge, no step
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h80, 16'd255, 8'hFF, 3'd1, 1'b1}; // 0xFF00 still attack
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h80, 16'd1,   8'hFF, 3'd2, 1'b1}; // 0xFFFF -> decay
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h80, 16'd127, 8'h80, 3'd2, 1'b1}; // 0x80FF still decay
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h80, 16'd1,   8'h80, 3'd3, 1'b1}; // 0x8000 sustain
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h40, 16'd3,   8'h80, 3'd3, 1'b1}; // no tick, no update
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h40, 16'd1,   8'h40, 3'd3, 1'b1}; // tracks sustain
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h80, 16'd1,   8'h80, 3'd3, 1'b1}; // back to 0x8000
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h80, 16'd1,   8'h80, 3'd4, 1'b1}; // release, level kept
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h80, 16'd127, 8'h01, 3'd4, 1'b1}; // 0x0100
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h80, 16'd1,   8'h00, 3'd0, 1'b0}; // idle

        for (int i = 0; i < 13; i++) begin
            rst           = vecs[i].rst;
            gate          = vecs[i].gate;
            tick          = vecs[i].tick;
            sustain_level = vecs[i].sus;
            run(int'(vecs[i].cycles));
            check_out($sformatf("vec%0d", i), vecs[i].exp_gain,
                      vecs[i].exp_state, vecs[i].exp_active);
        end

        // Retrigger mid-release at 0x3000, gate edge coincident with tick.
        sustain_level = 8'h80;
        do_reset();
        gate = 1'b1;
        run(1);
        run(64);
        check_out("retrig_attack_4000", 8'h40, 3'd1, 1'b1);
        gate = 1'b0;
        run(1);
        check_out("retrig_release_entry", 8'h40, 3'd4, 1'b1);
        run(16);
        check_out("retrig_release_3000", 8'h30, 3'd4, 1'b1);
        gate = 1'b1;
        run(1);
        check_out("retrig_edge_with_tick", 8'h30, 3'd1, 1'b1);
        run(1);
        check_out("retrig_first_step", 8'h31, 3'd1, 1'b1);

        // Gate edge with tick from idle: first increment on the next tick.
        do_reset();
        gate = 1'b1;
        run(1);
        check_out("edge_tick_idle", 8'h00, 3'd1, 1'b1);
        run(1);
        check_out("edge_tick_next", 8'h01, 3'd1, 1'b1);

        // Reset mid-attack with gate held high.
        do_reset();
        gate = 1'b1;
        run(1);
        run(10);
        check_out("rst_pre_attack", 8'h0A, 3'd1, 1'b1);
        rst = 1'b1;
        run(1);
        check_out("rst_abort", 8'h00, 3'd0, 1'b0);
        run(1);
        check_out("rst_held_gate_high", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        run(1);
        check_out("rst_release_attack", 8'h00, 3'd1, 1'b1);
        run(1);
        check_out("rst_release_step", 8'h01, 3'd1, 1'b1);

        // Slowest attack: step 1, gain 0x01 after 256 ticks.
        attack_rate = 8'h00;
        do_reset();
        gate = 1'b1;
        run(1);
        run(255);
        check_out("slow_attack_255", 8'h00, 3'd1, 1'b1);
        run(1);
        check_out("slow_attack_256", 8'h01, 3'd1, 1'b1);
        attack_rate = 8'hFF;

        // Zero sustain: silent but active until gate falls.
        sustain_level = 8'h00;
        do_reset();
        gate = 1'b1;
        run(1);
        run(256);
        check_out("zs_decay_entry", 8'hFF, 3'd2, 1'b1);
        run(256);
        check_out("zs_sustain", 8'h00, 3'd3, 1'b1);
        run(5);
        check_out("zs_sustain_hold", 8'h00, 3'd3, 1'b1);
        gate = 1'b0;
        run(1);
        check_out("zs_release", 8'h00, 3'd4, 1'b1);
        run(1);
        check_out("zs_idle", 8'h00, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_envelope_generator

// File: doc/envelope_generator.md
ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: clk  input  1  system clock, all state updates on rising edge.
REQ-002 rst  input  1  synchronous active-high reset.
REQ-003 tick  input  1  sample-rate strobe, one clk wide; level advances only on cycles with tick=1.
REQ-004 gate  input  1  note-on level; high = key held.
REQ-005 attack_rate  input  8  attack step control, step = attack_rate+1 per tick.
REQ-006 decay_rate  input  8  decay step control, step = decay_rate+1 per tick.
REQ-007 sustain_level  input  8  sustain gain; 8'hFF = full, 8'h00 = silent.
REQ-008 release_rate  input  8  release step control, step = release_rate+1 per tick.
REQ-009 gain  output  8  envelope gain for the wave gain stage; 8'hFF = -0 dB, 8'h00 = -inf dB.
REQ-010 active  output  1  high whenever state != IDLE.
REQ-011 env_state  output  3  current state encoding, for debug.

Function
REQ-012 Internal 16-bit unsigned level register; gain SHALL equal level[15:8] at all times (no extra pipeline stage).
REQ-013 States and encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; other codes SHALL return to IDLE on the next cycle.
REQ-014 gate rising edge SHALL be detected against a registered gate_d; rising edge in any state -> ATTACK next cycle, level retained (legato retrigger, no jump to 0).
REQ-015 gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE next cycle, level retained.
REQ-016 Gate-driven transitions SHALL be evaluated every clk; on a cycle with a gate transition, level SHALL NOT change even if tick=1.
REQ-017 ATTACK on tick: if level + step > 16'hFFFF, level <= 16'hFFFF and state -> DECAY; else level <= level + step. 17-bit sum, no wrap.
REQ-018 DECAY on tick: target = {sustain_level, 8'h00}; if level <= target + step (compare in 17 bits), level <= target and state -> SUSTAIN; else level <= level - step.
REQ-019 SUSTAIN on tick: level <= {sustain_level, 8'h00} (tracks live sustain changes).
REQ-020 RELEASE on tick: if level <= step, level <= 0 and state -> IDLE; else level <= level - step.
REQ-021 IDLE: level held at 0; gate high with gate_d low -> ATTACK.
REQ-022 Rate and sustain inputs SHALL be sampled on each tick; changes mid-phase take effect on the next tick.
REQ-023 sustain_level=8'h00 SHALL give SUSTAIN with gain 0 and active=1 until gate falls.

Reset
REQ-024 While rst=1 at a clk edge: state <= IDLE, level <= 0, gate_d <= 0; hence gain=8'h00, active=0, env_state=0 the cycle after.
REQ-025 rst SHALL override gate and tick; reset mid-envelope aborts to IDLE with no release phase.
REQ-026 If gate is high when rst deasserts, the first non-reset cycle SHALL see a rising edge and enter ATTACK.

Structure
REQ-027 State encodings, level width (16) and gain width (8) SHALL live in the shared synth definitions include file used by the oscillator blocks.
REQ-028 One sub-module, envelope_step: saturating 16-bit add/subtract of a 9-bit step against a 16-bit bound, returning new level and a reached flag; used by ATTACK, DECAY and RELEASE.
REQ-029 gain SHALL connect directly to the gain input of the wave gain stage without glue logic.

Verification
REQ-030 Attack: rates all 8'hFF, sustain 8'h80, gate high, tick every cycle -> 256 ticks to level 16'hFFFF, gain 8'hFF, state DECAY.
REQ-031 Decay: continuing REQ-030 -> 128 ticks to level 16'h8000, gain 8'h80, state SUSTAIN; sustain changed to 8'h40 -> gain 8'h40 after next tick.
REQ-032 Release: from level 16'h8000, gate low, release_rate 8'hFF -> RELEASE next cycle, 128 ticks to level 0, state IDLE, active 0.
REQ-033 Retrigger: gate toggled low then high mid-RELEASE at level 16'h3000 -> ATTACK from 16'h3000, no drop to 0.
REQ-034 Simultaneous: gate rising edge coincident with tick -> state ATTACK, level unchanged that cycle; increments start on next tick.
REQ-035 Reset mid-ATTACK with gate held high -> gain 8'h00 after reset edge; ATTACK re-entered first cycle after rst falls.
